// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I/D core ports and SRAM port bundled for the memory arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_en;
  logic [3:0]    m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    output i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port SRAM between fetch (I) and load/store (D)
// Registered IDLE/ISSUE/WAIT FSM with wait-state counter and alternating priority.
module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          grant_d;
  logic          last_d;
  logic          store_q;
  logic          i_elig;
  logic          d_elig;
  logic          pick_d;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] rdata_now;

  // A port is not re-granted in the cycle its own ready pulse is out.
  always_comb begin
    i_elig    = bus.i_req & ~bus.i_ready;
    d_elig    = bus.d_req & ~bus.d_ready;
    pick_d    = d_elig & (~i_elig | ~last_d);
    sel_addr  = pick_d ? bus.d_addr : bus.i_addr;
    rdata_now = bus.m_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      grant_d     <= 1'b0;
      last_d      <= 1'b0;
      store_q     <= 1'b0;
      bus.m_en    <= 1'b0;
      bus.m_we    <= '0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_elig || d_elig) begin
            grant_d    <= pick_d;
            store_q    <= pick_d & bus.d_we;
            bus.m_addr <= sel_addr;
            if (pick_d) begin
              bus.m_wdata <= bus.d_wdata;
            end
            // Strobe and byte enables are set here so they are visible in ISSUE.
            bus.m_en <= 1'b1;
            bus.m_we <= (pick_d && bus.d_we) ? bus.d_be : 4'b0000;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.m_en <= 1'b0;
          bus.m_we <= 4'b0000;
          cnt      <= CNT_INIT;
          last_d   <= grant_d;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            if (grant_d) begin
              bus.d_ready <= 1'b1;
              if (!store_q) begin
                bus.d_rdata <= rdata_now;
              end
            end else begin
              bus.i_ready <= 1'b1;
              bus.i_rdata <= rdata_now;
            end
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with 1- and 3-cycle SRAM models
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   c0;
  exp_t qi[$];
  exp_t qd[$];
  exp_t qd3[$];
  exp_t e;

  logic [31:0] mem [0:255];
  logic [31:0] rd1;
  logic [31:0] r3a, r3b, r3c;

  mem_arbiter_if #(.AW(32), .DW(32)) b1();
  mem_arbiter_if #(.AW(32), .DW(32)) b3();

  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: u1 sees data one cycle after m_en, u3 three cycles after.
  always @(posedge clk) begin
    if (b1.m_en) begin
      rd1 <= mem[b1.m_addr[9:2]];
      for (int k = 0; k < 4; k++) begin
        if (b1.m_we[k]) mem[b1.m_addr[9:2]][8*k +: 8] <= b1.m_wdata[8*k +: 8];
      end
    end
    if (b3.m_en) r3a <= mem[b3.m_addr[9:2]];
    r3b <= r3a;
    r3c <= r3b;
  end
  assign b1.m_rdata = rd1;
  assign b3.m_rdata = r3c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input int sel);
    logic seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      case (sel)
        0:       seen = b1.i_ready;
        1:       seen = b1.d_ready;
        default: seen = b3.d_ready;
      endcase
    end
    if (!seen) chk("ready_timeout", {31'b0, seen}, 32'd1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b1.i_req = 1'b0;
    b1.d_req = 1'b0;
    b1.d_we  = 1'b0;
    b3.d_req = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_m_en", {31'b0, b1.m_en}, 32'd0);
    chk("rst_m_we", {28'b0, b1.m_we}, 32'd0);
    chk("rst_m_addr", b1.m_addr, 32'd0);
    chk("rst_m_wdata", b1.m_wdata, 32'd0);
    chk("rst_i_ready", {31'b0, b1.i_ready}, 32'd0);
    chk("rst_d_ready", {31'b0, b1.d_ready}, 32'd0);
    chk("rst_i_rdata", b1.i_rdata, 32'd0);
    chk("rst_d_rdata", b1.d_rdata, 32'd0);
    step();
  endtask

  // Scoreboard: every ready pulse must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (b1.i_ready || b1.d_ready) chk("excl", {31'b0, b1.i_ready & b1.d_ready}, 32'd0);
      if (b1.i_ready) begin
        if (qi.size() == 0) chk("i_extra", {31'b0, b1.i_ready}, 32'd0);
        else begin
          e = qi.pop_front();
          chk("i_data", b1.i_rdata, e.data);
          chk("i_cyc", cyc, e.cyc);
        end
      end
      if (b1.d_ready) begin
        if (qd.size() == 0) chk("d_extra", {31'b0, b1.d_ready}, 32'd0);
        else begin
          e = qd.pop_front();
          chk("d_data", b1.d_rdata, e.data);
          chk("d_cyc", cyc, e.cyc);
        end
      end
      if (b3.d_ready) begin
        if (qd3.size() == 0) chk("d3_extra", {31'b0, b3.d_ready}, 32'd0);
        else begin
          e = qd3.pop_front();
          chk("d3_data", b3.d_rdata, e.data);
          chk("d3_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
    mem[8'h40] <= 32'hDEADBEEF;
    mem[8'h10] <= 32'hAABBCCDD;
    mem[8'h80] <= 32'h0D0D0D0D;
    mem[8'h81] <= 32'h11111111;
    mem[8'h82] <= 32'h55AA55AA;
    {b1.i_req, b1.d_req, b1.d_we} = '0;
    {b3.i_req, b3.d_req, b3.d_we} = '0;
    b1.i_addr = '0; b1.d_addr = '0; b1.d_be = '0; b1.d_wdata = '0;
    b3.i_addr = '0; b3.d_addr = '0; b3.d_be = '0; b3.d_wdata = '0;

    // fetch latency and single pulse
    do_reset();
    rst = 1'b0; b1.i_req = 1'b1; b1.i_addr = 32'h100;
    c0 = cyc; qi.push_back('{32'hDEADBEEF, c0 + 3});
    @(negedge clk); chk("t1_en_c0", {31'b0, b1.m_en}, 32'd0);
    step();
    @(negedge clk);
    chk("t1_en_c1", {31'b0, b1.m_en}, 32'd1);
    chk("t1_addr", b1.m_addr, 32'h100);
    chk("t1_we", {28'b0, b1.m_we}, 32'd0);
    wait_rdy(0);
    b1.i_req = 1'b0;
    @(negedge clk); chk("t1_pulse", {31'b0, b1.i_ready}, 32'd0);

    // load, partial store, reload
    do_reset();
    rst = 1'b0; b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h40;
    qd.push_back('{32'hAABBCCDD, cyc + 3});
    wait_rdy(1);
    b1.d_we = 1'b1; b1.d_be = 4'b0011; b1.d_wdata = 32'h12345678;
    qd.push_back('{32'hAABBCCDD, cyc + 3});
    @(negedge clk); chk("t2_we_c0", {28'b0, b1.m_we}, 32'd0);
    step();
    @(negedge clk); chk("t2_we_c1", {28'b0, b1.m_we}, 32'h3);
    step();
    @(negedge clk); chk("t2_we_c2", {28'b0, b1.m_we}, 32'd0);
    wait_rdy(1);
    b1.d_we = 1'b0;
    qd.push_back('{32'hAABB5678, cyc + 3});
    wait_rdy(1);
    b1.d_req = 1'b0;

    // continuous contention alternates D, I, D, I
    do_reset();
    rst = 1'b0;
    b1.i_req = 1'b1; b1.i_addr = 32'h204;
    b1.d_req = 1'b1; b1.d_addr = 32'h200;
    c0 = cyc;
    qd.push_back('{32'h0D0D0D0D, c0 + 3});
    qi.push_back('{32'h11111111, c0 + 6});
    qd.push_back('{32'h0D0D0D0D, c0 + 9});
    qi.push_back('{32'h11111111, c0 + 12});
    repeat (10) step();
    b1.d_req = 1'b0;
    repeat (3) step();
    b1.i_req = 1'b0;
    repeat (2) step();

    // D held through its ready cycle is masked there, re-granted one cycle later
    do_reset();
    rst = 1'b0; b1.d_req = 1'b1; b1.d_addr = 32'h200;
    c0 = cyc;
    qd.push_back('{32'h0D0D0D0D, c0 + 3});
    qd.push_back('{32'h0D0D0D0D, c0 + 7});
    repeat (4) step();
    @(negedge clk); chk("t4_no_regrant", {31'b0, b1.m_en}, 32'd0);
    step();
    @(negedge clk); chk("t4_regrant", {31'b0, b1.m_en}, 32'd1);
    repeat (3) step();
    b1.d_req = 1'b0;
    repeat (2) step();

    // three wait states
    do_reset();
    rst = 1'b0; b3.d_req = 1'b1; b3.d_addr = 32'h208;
    qd3.push_back('{32'h55AA55AA, cyc + 5});
    step();
    @(negedge clk); chk("t5_en_c1", {31'b0, b3.m_en}, 32'd1);
    step();
    @(negedge clk); chk("t5_en_c2", {31'b0, b3.m_en}, 32'd0);
    wait_rdy(2);
    b3.d_req = 1'b0;

    // reset in WAIT abandons the access, then the held request is served afresh
    do_reset();
    rst = 1'b0; b1.i_req = 1'b1; b1.i_addr = 32'h100;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    qi.push_back('{32'hDEADBEEF, cyc + 3});
    @(negedge clk);
    chk("t6_en", {31'b0, b1.m_en}, 32'd0);
    chk("t6_addr", b1.m_addr, 32'd0);
    chk("t6_rdy", {31'b0, b1.i_ready}, 32'd0);
    wait_rdy(0);
    b1.i_req = 1'b0;
    repeat (3) step();

    chk("qi_left", qi.size(), 32'd0);
    chk("qd_left", qd.size(), 32'd0);
    chk("qd3_left", qd3.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
